elevator_ctrl_n: RTL and testbench
==================================

# elevator_ctrl_n

Parametrised N-floor elevator controller: latches per-floor call requests, serves them in SCAN order (continue in current direction while calls remain ahead, else reverse), times floor-to-floor travel and door dwell, and holds the door open while the obstruction sensor is asserted. It sits between the floor call-button inputs and the car/door drive outputs. It is the multi-floor, request-queuing successor to the fixed 3-floor controller.

## Interface
- NUM_FLOORS, 4, number of floors, >= 2; floor 0 is the lowest
- DOOR_CYCLES, 4, door-open dwell in clock cycles, >= 1
- TRAVEL_CYCLES, 3, cycles to travel one floor, >= 1

- clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  NUM_FLOORS  call request, bit i = floor i; level or pulse, sampled every cycle
- Blk  in  1  door obstruction; only meaningful in DOOR_OPEN
- Floor  out  NUM_FLOORS  one-hot current car floor
- Door  out  1  door open
- Moving  out  1  car travelling between floors
- Dir  out  1  travel direction, 1 = up, 0 = down
- Pending  out  NUM_FLOORS  latched outstanding calls

## Operation
- All outputs are registered. Counters are $clog2(max+1) bits wide.
- Effective calls E = Pending | Req. Every cycle Pending <= Pending | Req, except for the clears below.
- States: IDLE, DOOR_OPEN, MOVE.
- IDLE, priority order:
  - E[cur] set -> DOOR_OPEN. Clear Pending[cur]. Load the door timer with DOOR_CYCLES.
  - Else if any E above cur and (Dir=1 or no E below) -> MOVE. Set Dir=1 and load the travel timer with TRAVEL_CYCLES.
  - Else if any E below cur -> MOVE. Set Dir=0 and load the travel timer.
  - Else stay in IDLE; Dir holds.
- DOOR_OPEN: Door=1. Req[cur] is never latched here and reloads the timer. Blk=1 reloads the timer. The timer decrements each cycle otherwise. When timer==1, Blk=0 and Req[cur]=0 -> IDLE.
- MOVE: Moving=1. The travel timer decrements each cycle. When timer==1, cur moves by +1 (Dir=1) or -1 (Dir=0), Floor updates, and the state goes to IDLE. The car always stops in IDLE at each floor, for one decision cycle.
- The car never moves past floor 0 or NUM_FLOORS-1; a move starts only toward an existing call.
- Req bits arriving during MOVE, including the destination floor, are latched and served on a later IDLE evaluation.
- Blk is ignored in IDLE and MOVE. If Blk is held permanently, the door stays open indefinitely while Pending keeps accumulating.
- Reset, including mid-move or with the door open: state=IDLE, cur=0, Dir=1, timers=0, Pending cleared. The controller re-homes to floor 0 and does not complete the interrupted move.

## Timing
- Reset values: Floor=1 (floor 0), Door=0, Moving=0, Dir=1, Pending=0.
- Call at current floor while IDLE, Req high in cycle k: Door=1 from cycle k+1. The door stays open exactly DOOR_CYCLES cycles with no Blk/Req[cur], then spends at least 1 cycle with Door=0 in IDLE.
- Each one-floor hop takes TRAVEL_CYCLES cycles with Moving=1, followed by 1 IDLE cycle at the new floor.
- Blk asserted in the last door cycle extends the door by DOOR_CYCLES cycles counted from the first cycle Blk is low.
- Door and Moving are never both 1.
- When Req[cur] and other calls are asserted in the same IDLE cycle, the door opens first.

## Test plan
- Reset, then Req=0001 for 1 cycle with defaults -> Door=1 for cycles 1..4, Door=0 at cycle 5, Pending stays 0000.
- From floor 0, pulse Req=0100 -> Moving=1 for 3 cycles, Floor=0010, 1 IDLE cycle, Moving=1 for 3 cycles, Floor=0100, Door=1 the next cycle for 4 cycles; Pending[2] clears when the door opens.
- At floor 1 going up with Pending=1001 -> car serves floor 3 first, then reverses (Dir=0) and serves floor 0.
- Door open at floor 2 with Blk high for 10 cycles -> Door stays 1 throughout, then for 4 more cycles after Blk falls; Req=0001 during this time latches into Pending[0].
- Assert Reset mid-MOVE between floors 2 and 3 -> the next cycle shows Floor=0001, Moving=0, Door=0, Dir=1, Pending=0000.
- NUM_FLOORS=8, DOOR_CYCLES=1, TRAVEL_CYCLES=1: simultaneous Req=10000001 at floor 0 -> door opens at floor 0 first, then the car climbs 7 floors at 2 cycles per floor and opens at floor 7.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller.
// Latches floor calls, serves them in SCAN order, times floor-to-floor travel
// and door dwell, and holds the door open while the obstruction sensor is high.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 4,
  parameter int DOOR_CYCLES   = 4,
  parameter int TRAVEL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [NUM_FLOORS-1:0] Req,
  input  logic                  Blk,
  output logic [NUM_FLOORS-1:0] Floor,
  output logic                  Door,
  output logic                  Moving,
  output logic                  Dir,
  output logic [NUM_FLOORS-1:0] Pending
);

  localparam int CW   = $clog2(NUM_FLOORS);
  localparam int TMAX = (DOOR_CYCLES > TRAVEL_CYCLES) ? DOOR_CYCLES : TRAVEL_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DOOR_OPEN = 2'd1,
    S_MOVE      = 2'd2
  } state_t;

  state_t                r_state,   w_state_nxt;
  logic [CW-1:0]         r_cur,     w_cur_nxt;
  logic [TW-1:0]         r_timer,   w_timer_nxt;
  logic                  r_dir,     w_dir_nxt;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
  logic [NUM_FLOORS-1:0] r_floor;
  logic                  r_door;
  logic                  r_moving;

  logic [NUM_FLOORS-1:0] w_eff;
  logic [NUM_FLOORS-1:0] w_here;
  logic [NUM_FLOORS-1:0] w_floor_nxt;
  logic                  w_any_above;
  logic                  w_any_below;

  // Effective calls include this cycle's requests; w_here masks the car's own floor.
  assign w_eff  = r_pending | Req;
  assign w_here = ONE << r_cur;

  // Look for outstanding calls strictly above and strictly below the car.
  always_comb begin
    w_any_above = 1'b0;
    w_any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_eff[i]) begin
        if (i > int'(r_cur)) w_any_above = 1'b1;
        if (i < int'(r_cur)) w_any_below = 1'b1;
      end
    end
  end

  // Next-state logic: SCAN decision in IDLE, dwell timing in DOOR_OPEN, travel in MOVE.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_timer_nxt   = r_timer;
    w_dir_nxt     = r_dir;
    w_pending_nxt = w_eff;

    case (r_state)
      S_IDLE: begin
        if (w_eff[r_cur]) begin
          w_state_nxt   = S_DOOR_OPEN;
          w_pending_nxt = w_eff & ~w_here;
          w_timer_nxt   = TW'(DOOR_CYCLES);
        end else if (w_any_above && (r_dir || !w_any_below)) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = 1'b1;
          w_timer_nxt = TW'(TRAVEL_CYCLES);
        end else if (w_any_below) begin
          w_state_nxt = S_MOVE;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = TW'(TRAVEL_CYCLES);
        end
      end

      S_DOOR_OPEN: begin
        // A call at the open floor is absorbed: it only keeps the door open.
        w_pending_nxt = r_pending | (Req & ~w_here);
        if (Blk || Req[r_cur]) begin
          w_timer_nxt = TW'(DOOR_CYCLES);
        end else if (r_timer == TW'(1)) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      S_MOVE: begin
        if (r_timer == TW'(1)) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_cur_nxt   = r_dir ? (r_cur + CW'(1)) : (r_cur - CW'(1));
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign w_floor_nxt = ONE << w_cur_nxt;

  // State and registered outputs; reset re-homes the car to floor 0 heading up.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_timer   <= '0;
      r_dir     <= 1'b1;
      r_pending <= '0;
      r_floor   <= ONE;
      r_door    <= 1'b0;
      r_moving  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_timer   <= w_timer_nxt;
      r_dir     <= w_dir_nxt;
      r_pending <= w_pending_nxt;
      r_floor   <= w_floor_nxt;
      r_door    <= (w_state_nxt == S_DOOR_OPEN);
      r_moving  <= (w_state_nxt == S_MOVE);
    end
  end

  assign Floor   = r_floor;
  assign Door    = r_door;
  assign Moving  = r_moving;
  assign Dir     = r_dir;
  assign Pending = r_pending;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Testbench for elevator_ctrl_n: a default 4-floor car (A) and an 8-floor,
// 1-cycle-timing car (B), each checked against a behavioural model.
module tb_elevator_ctrl_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Car A: NUM_FLOORS=4, DOOR_CYCLES=4, TRAVEL_CYCLES=3
  logic       a_rst, a_blk;
  logic [3:0] a_req;
  logic [3:0] a_floor, a_pend;
  logic       a_door, a_moving, a_dir;
  logic [10:0] a_vec;
  assign a_vec = {a_floor, a_door, a_moving, a_dir, a_pend};

  // Car B: NUM_FLOORS=8, DOOR_CYCLES=1, TRAVEL_CYCLES=1
  logic       b_rst, b_blk;
  logic [7:0] b_req;
  logic [7:0] b_floor, b_pend;
  logic       b_door, b_moving, b_dir;
  logic [18:0] b_vec;
  assign b_vec = {b_floor, b_door, b_moving, b_dir, b_pend};

  elevator_ctrl_n #(.NUM_FLOORS(4), .DOOR_CYCLES(4), .TRAVEL_CYCLES(3)) dut_a (
    .clk(clk), .Reset(a_rst), .Req(a_req), .Blk(a_blk),
    .Floor(a_floor), .Door(a_door), .Moving(a_moving), .Dir(a_dir), .Pending(a_pend)
  );

  elevator_ctrl_n #(.NUM_FLOORS(8), .DOOR_CYCLES(1), .TRAVEL_CYCLES(1)) dut_b (
    .clk(clk), .Reset(b_rst), .Req(b_req), .Blk(b_blk),
    .Floor(b_floor), .Door(b_door), .Moving(b_moving), .Dir(b_dir), .Pending(b_pend)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model: car described by floor number and remaining door/travel cycles.
  typedef struct packed {
    int         floor;
    int         door_left;
    int         travel_left;
    bit         dir;
    logic [7:0] pend;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t s, logic [7:0] req, logic blk, logic rst,
                                    int nf, int dc, int tc);
    mstate_t    n;
    logic [7:0] here;
    logic [7:0] e;
    bit         up;
    bit         dn;
    n    = s;
    here = 8'(1) << s.floor;
    e    = s.pend | req;
    up   = 0;
    dn   = 0;
    if (rst) begin
      n.floor = 0; n.door_left = 0; n.travel_left = 0; n.dir = 1; n.pend = '0;
      return n;
    end
    if (s.door_left > 0) begin
      n.pend      = s.pend | (req & ~here);
      n.door_left = (blk || req[s.floor]) ? dc : s.door_left - 1;
    end else if (s.travel_left > 0) begin
      n.pend        = e;
      n.travel_left = s.travel_left - 1;
      if (n.travel_left == 0) n.floor = s.dir ? s.floor + 1 : s.floor - 1;
    end else begin
      for (int i = 0; i < nf; i++) begin
        if (e[i] && i > s.floor) up = 1;
        if (e[i] && i < s.floor) dn = 1;
      end
      n.pend = e;
      if (e[s.floor]) begin
        n.door_left = dc;
        n.pend      = e & ~here;
      end else if (up && (s.dir || !dn)) begin
        n.dir = 1; n.travel_left = tc;
      end else if (dn) begin
        n.dir = 0; n.travel_left = tc;
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] exp_a(mstate_t s);
    logic [7:0] oh;
    oh = 8'(1) << s.floor;
    return {oh[3:0], (s.door_left > 0), (s.travel_left > 0), s.dir, s.pend[3:0]};
  endfunction

  function automatic logic [18:0] exp_b(mstate_t s);
    logic [7:0] oh;
    oh = 8'(1) << s.floor;
    return {oh, (s.door_left > 0), (s.travel_left > 0), s.dir, s.pend};
  endfunction

  // One clock: models consume the inputs seen at the edge; outputs settle 1 time unit later.
  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, {4'b0, a_req}, a_blk, a_rst, 4, 4, 3);
    mb = mstep(mb, b_req, b_blk, b_rst, 8, 1, 1);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; a_req = '0; b_req = '0; a_blk = 0; b_blk = 0;
    tick();
    n_checks++;
    if (a_vec !== 11'b0001_0_0_1_0000) begin
      n_fails++; $display("FAIL reset_a: got %b expected %b", a_vec, 11'b0001_0_0_1_0000);
    end
    n_checks++;
    if (b_vec !== {8'h01, 3'b001, 8'h00}) begin
      n_fails++; $display("FAIL reset_b: got %b expected %b", b_vec, {8'h01, 3'b001, 8'h00});
    end
    a_rst = 0; b_rst = 0;
    tick();
    n_checks++;
    if (a_vec !== exp_a(ma)) begin
      n_fails++; $display("FAIL idle_after_reset: got %b expected %b", a_vec, exp_a(ma));
    end
  endtask

  task automatic test_door_cycle();
    a_req = 4'b0001;
    tick();
    a_req = '0;
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if (a_door !== (c <= 4) || a_pend !== 4'b0000) begin
        n_fails++; $display("FAIL door_cycle c=%0d: door=%b pend=%b expected door=%b pend=0000",
                            c, a_door, a_pend, (c <= 4));
      end
      n_checks++;
      if (a_vec !== exp_a(ma)) begin
        n_fails++; $display("FAIL door_cycle_model c=%0d: got %b expected %b", c, a_vec, exp_a(ma));
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_travel();
    logic [3:0] ef;
    logic       ed, em, ep;
    a_req = 4'b0100;
    tick();
    a_req = '0;
    for (int c = 1; c <= 13; c++) begin
      em = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      ef = (c < 4) ? 4'b0001 : (c < 8) ? 4'b0010 : 4'b0100;
      ed = (c >= 9 && c <= 12);
      ep = (c <= 8);
      n_checks++;
      if ({a_floor, a_door, a_moving, a_pend[2]} !== {ef, ed, em, ep}) begin
        n_fails++; $display("FAIL travel c=%0d: floor=%b door=%b moving=%b pend2=%b expected %b %b %b %b",
                            c, a_floor, a_door, a_moving, a_pend[2], ef, ed, em, ep);
      end
      n_checks++;
      if (a_vec !== exp_a(ma)) begin
        n_fails++; $display("FAIL travel_model c=%0d: got %b expected %b", c, a_vec, exp_a(ma));
      end
      tick();
    end
  endtask

  task automatic test_scan();
    logic [3:0] opened[$];
    logic       prev_door;
    a_rst = 1; tick(); a_rst = 0;
    a_req = 4'b0010; tick(); a_req = '0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (a_vec !== 11'b0010_0_0_1_0000) begin
      n_fails++; $display("FAIL scan_setup: got %b expected %b", a_vec, 11'b0010_0_0_1_0000);
    end
    a_req = 4'b1001;
    prev_door = a_door;
    tick();
    a_req = '0;
    for (int i = 0; i < 60; i++) begin
      n_checks++;
      if (a_vec !== exp_a(ma)) begin
        n_fails++; $display("FAIL scan_model i=%0d: got %b expected %b", i, a_vec, exp_a(ma));
      end
      if (a_door && !prev_door) begin
        opened.push_back(a_floor);
        if (a_floor == 4'b0001) begin
          n_checks++;
          if (a_dir !== 1'b0) begin
            n_fails++; $display("FAIL scan_reverse_dir: got %b expected 0", a_dir);
          end
        end
      end
      prev_door = a_door;
      tick();
    end
    n_checks++;
    if (opened.size() < 2 || opened[0] !== 4'b1000 || opened[1] !== 4'b0001) begin
      n_fails++; $display("FAIL scan_order: %0d door openings, first=%b second=%b expected 1000 then 0001",
                          opened.size(), (opened.size() > 0) ? opened[0] : 4'bx,
                          (opened.size() > 1) ? opened[1] : 4'bx);
    end
  endtask

  task automatic test_block();
    int budget;
    a_rst = 1; tick(); a_rst = 0;
    a_req = 4'b0100; tick(); a_req = '0;
    budget = 0;
    while (!a_door && budget < 30) begin
      tick();
      budget++;
    end
    n_checks++;
    if (a_door !== 1'b1 || a_floor !== 4'b0100) begin
      n_fails++; $display("FAIL block_reach_timeout: door=%b floor=%b expected 1 0100", a_door, a_floor);
    end
    a_blk = 1;
    for (int i = 0; i < 10; i++) begin
      a_req = (i == 3) ? 4'b0001 : (i == 6) ? 4'b0100 : 4'b0000;
      tick();
      n_checks++;
      if (a_door !== 1'b1 || a_vec !== exp_a(ma)) begin
        n_fails++; $display("FAIL block_hold i=%0d: got %b expected %b", i, a_vec, exp_a(ma));
      end
    end
    a_blk = 0; a_req = '0;
    n_checks++;
    if (a_pend !== 4'b0001) begin
      n_fails++; $display("FAIL block_pending: got %b expected 0001", a_pend);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (a_door !== (c <= 3) || a_moving !== 1'b0) begin
        n_fails++; $display("FAIL block_release c=%0d: door=%b moving=%b expected door=%b moving=0",
                            c, a_door, a_moving, (c <= 3));
      end
    end
  endtask

  task automatic test_reset_mid_move();
    int budget;
    a_rst = 1; tick(); a_rst = 0;
    a_req = 4'b1000; tick(); a_req = '0;
    budget = 0;
    while (!(a_floor == 4'b0100 && a_moving) && budget < 40) begin
      tick();
      budget++;
    end
    n_checks++;
    if (a_floor !== 4'b0100 || a_moving !== 1'b1) begin
      n_fails++; $display("FAIL midmove_reach_timeout: floor=%b moving=%b expected 0100 1", a_floor, a_moving);
    end
    a_rst = 1;
    tick();
    a_rst = 0;
    n_checks++;
    if (a_vec !== 11'b0001_0_0_1_0000) begin
      n_fails++; $display("FAIL midmove_reset: got %b expected %b", a_vec, 11'b0001_0_0_1_0000);
    end
  endtask

  task automatic test_eight_floor();
    int arrive;
    b_rst = 1; tick(); b_rst = 0;
    b_req = 8'h81;
    tick();
    b_req = '0;
    n_checks++;
    if (b_door !== 1'b1 || b_floor !== 8'h01) begin
      n_fails++; $display("FAIL eight_first_door: door=%b floor=%h expected 1 01", b_door, b_floor);
    end
    arrive = -1;
    for (int c = 1; c <= 20; c++) begin
      n_checks++;
      if (b_vec !== exp_b(mb)) begin
        n_fails++; $display("FAIL eight_model c=%0d: got %b expected %b", c, b_vec, exp_b(mb));
      end
      if (arrive < 0 && b_door && b_floor == 8'h80) arrive = c;
      tick();
    end
    n_checks++;
    if (arrive != 17) begin
      n_fails++; $display("FAIL eight_arrival_cycle: got %0d expected 17", arrive);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      a_req = ($urandom_range(0, 4) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      a_blk = ($urandom_range(0, 5) == 0);
      a_rst = ($urandom_range(0, 399) == 0);
      b_req = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'b0;
      b_blk = ($urandom_range(0, 5) == 0);
      b_rst = ($urandom_range(0, 399) == 0);
      tick();
      n_checks++;
      if (a_vec !== exp_a(ma)) begin
        n_fails++; $display("FAIL random_a i=%0d: got %b expected %b", i, a_vec, exp_a(ma));
      end
      n_checks++;
      if (b_vec !== exp_b(mb)) begin
        n_fails++; $display("FAIL random_b i=%0d: got %b expected %b", i, b_vec, exp_b(mb));
      end
      n_checks++;
      if ((a_door && a_moving) || (b_door && b_moving)) begin
        n_fails++; $display("FAIL door_and_moving i=%0d: a=%b%b b=%b%b expected never both",
                            i, a_door, a_moving, b_door, b_moving);
      end
    end
    a_req = '0; b_req = '0; a_blk = 0; b_blk = 0; a_rst = 0; b_rst = 0;
  endtask

  initial begin
    ma = '0;
    mb = '0;
    a_rst = 1; b_rst = 1; a_req = '0; b_req = '0; a_blk = 0; b_blk = 0;
    test_reset();
    test_door_cycle();
    test_travel();
    test_scan();
    test_block();
    test_reset_mid_move();
    test_eight_floor();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
